mul32: RTL and testbench

Sequential 32-bit sign-magnitude multiplier, the companion to the team's sequential divider. It uses the same operand format: bit 31 is the sign, bits [30:0] are the magnitude. It uses the same `start`/`en`/`done` handshake. It sits in the flight-controller arithmetic path, alongside the divider, for gain scaling and for reconstructing `quotient*divisor + remainder` checks. It performs one radix-2 shift-add step per enabled cycle and saturates results that do not fit in 31 magnitude bits.

---
 rtl/mul32.sv | 114 +++++++++++
 tb/tb_mul32.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul32.sv
// mul32: sequential 32-bit sign-magnitude multiplier, one radix-2 shift-add step per enabled
// cycle, with saturation of magnitudes that do not fit in 31 bits.
//
// Ports:
//   clk          in   rising-edge clock
//   nrst         in   synchronous active-low reset
//   en           in   clock enable; all registers hold when low
//   start        in   request a multiply (accepted only when idle)
//   multiplicand in   [31:0] sign-magnitude operand A
//   multiplier   in   [31:0] sign-magnitude operand B
//   product      out  [31:0] sign-magnitude result, registered
//   overflow     out  true product magnitude >= 2^31, registered
//   busy         out  operation in flight (until the done pulse is consumed)
//   done         out  one-enabled-cycle completion pulse
module mul32 (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] product,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [61:0] r_p;
    logic [30:0] r_m;
    logic [30:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic [31:0] r_product;
    logic        r_overflow;
    logic        r_done;

    logic [31:0] w_add;
    logic [31:0] w_sum;
    logic [61:0] w_p_shift;
    logic        w_ovf;
    logic [30:0] w_mag;
    logic        w_sign_out;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (r_cnt == 5'd30) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: add M into the upper half, keeping the carry so the shift loses nothing
    always_comb begin
        w_add      = r_q[0] ? {1'b0, r_m} : 32'd0;
        w_sum      = {1'b0, r_p[61:31]} + w_add;
        w_p_shift  = {w_sum, r_p[30:1]};
        w_ovf      = |r_p[61:31];
        w_mag      = w_ovf ? 31'h7FFF_FFFF : r_p[30:0];
        w_sign_out = r_sign & (w_mag != 31'd0);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= StIdle;
            r_p        <= '0;
            r_m        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else if (en) begin
            r_state <= w_state_next;
            r_done  <= (r_state == StDone);
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_m    <= multiplicand[30:0];
                        r_q    <= multiplier[30:0];
                        r_sign <= multiplicand[31] ^ multiplier[31];
                        r_p    <= '0;
                        r_cnt  <= '0;
                    end
                end
                StRun: begin
                    r_p   <= w_p_shift;
                    r_q   <= {1'b0, r_q[30:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                StDone: begin
                    r_overflow <= w_ovf;
                    r_product  <= {w_sign_out, w_mag};
                end
                default: ;
            endcase
        end
    end

    assign product  = r_product;
    assign overflow = r_overflow;
    assign done     = r_done;
    // The done-pulse cycle still counts as busy, even though a new start is already accepted
    // there, so busy drops only once the pulse is consumed.
    assign busy     = (r_state != StIdle) | r_done;

endmodule

// File: tb/tb_mul32.sv
module tb_mul32;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] product;
    logic        overflow;
    logic        busy;
    logic        done;

    mul32 dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic        ov;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: counts edges and scores every rising done against the scoreboard.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done === 1'b1 && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", product, e.p);
                    check("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    check("latency_edge", cyc, e.due);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic do_mul(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ep,
                          input logic eov, input int lat, input bit push);
        exp_t e;
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (push) begin
            e.p   = ep;
            e.ov  = eov;
            e.due = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ep,
                       input logic eov);
        do_mul(ia, ib, ep, eov, 32, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0;
        nrst  = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_product", product, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Basic with busy/done timing
        do_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 32, 1'b1);
        n0 = cyc;
        check("busy_at_N", {31'd0, busy}, 32'd1);
        repeat (31) @(negedge clk);
        check("busy_at_N31", {31'd0, busy}, 32'd1);
        check("done_at_N31", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("edge_N32", cyc, n0 + 32);
        check("busy_at_N32", {31'd0, busy}, 32'd1);
        check("done_at_N32", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("busy_at_N33", {31'd0, busy}, 32'd0);
        check("done_at_N33", {31'd0, done}, 32'd0);

        // Signs and boundaries
        run(32'h8000_0007, 32'h0000_0006, 32'h8000_002A, 1'b0);
        run(32'h8000_0007, 32'h8000_0006, 32'h0000_002A, 1'b0);
        run(32'h8000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0);
        run(32'h0001_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1);
        run(32'h8001_0000, 32'h0000_8000, 32'hFFFF_FFFF, 1'b1);
        run(32'h0000_7FFF, 32'h0001_0000, 32'h7FFF_0000, 1'b0);
        run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);

        // Start during RUN with new operands is ignored
        do_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 32, 1'b1);
        repeat (5) @(negedge clk);
        a     = 32'h0000_0007;
        b     = 32'h0000_0007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Back-to-back: second start in the done cycle, due at N+65
        do_mul(32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 1'b0, 32, 1'b1);
        wait_done();
        do_mul(32'h0000_0004, 32'h0000_0005, 32'h0000_0014, 1'b0, 32, 1'b1);
        wait_done();
        @(negedge clk);

        // Enable stretch: 10 disabled edges mid-RUN
        do_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 42, 1'b1);
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        wait_done();
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("done_held_en0", {31'd0, done}, 32'd1);
        check("product_held_en0", product, 32'h0000_000F);
        en = 1'b1;
        @(negedge clk);
        check("done_cleared", {31'd0, done}, 32'd0);

        // Reset mid-operation at N+15
        do_mul(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 32, 1'b0);
        repeat (14) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_product", product, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        nrst = 1'b1;
        repeat (40) @(negedge clk);
        run(32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
